// File: rtl/note_sequencer.sv
// Purpose : plays songs from an external note memory and produces freq_out plus an optional square-wave tone.
// Latency : a note entry is fetched in 2 cycles (FETCH, WAIT), then plays for dur cycles.
// Backpr. : none; ena low freezes every register, and key pulses are ignored while ena is low.
//
// Ports   : clk, rst_n (synchronous, active low), ena, key_play/key_next/key_menu (1-cycle pulses),
//           mem_addr/mem_rd -> note memory, mem_data <- {freq, dur} one cycle after mem_rd,
//           freq_out (0 = rest), tone, playing, menu, song_idx.
// Config  : define NOTE_SEQ_TONE_EN to build the half-period tone generator; otherwise tone is tied to 0.
module note_sequencer #(
  parameter int FREQ_W = 28,
  parameter int DUR_W = 28,
  parameter int ADDR_W = 7,
  parameter int N_SONGS = 3,
  parameter logic [N_SONGS*ADDR_W-1:0] SONG_BASE = {7'd58, 7'd34, 7'd1},
  localparam int SONG_W = (N_SONGS > 1) ? $clog2(N_SONGS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     key_play,
  input  logic                     key_next,
  input  logic                     key_menu,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_rd,
  input  logic [FREQ_W+DUR_W-1:0]  mem_data,
  output logic [FREQ_W-1:0]        freq_out,
  output logic                     tone,
  output logic                     playing,
  output logic                     menu,
  output logic [SONG_W-1:0]        song_idx
);

  localparam logic [2:0] S_MENU  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_PLAY  = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [SONG_W-1:0] song_idx_q, song_idx_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [DUR_W-1:0]  dur_cnt_q, dur_cnt_d;
  logic              pend_q, pend_d;   // pause requested while a note is being fetched

  logic [FREQ_W-1:0] ent_freq;
  logic [DUR_W-1:0]  ent_dur;
  logic [SONG_W-1:0] song_nxt;

  assign ent_freq = mem_data[FREQ_W+DUR_W-1:DUR_W];
  assign ent_dur  = mem_data[DUR_W-1:0];
  assign song_nxt = (song_idx_q == SONG_W'(N_SONGS - 1)) ? '0 : song_idx_q + SONG_W'(1);

  function automatic logic [ADDR_W-1:0] base_of(input logic [SONG_W-1:0] idx);
    logic [ADDR_W-1:0] b;
    b = SONG_BASE[ADDR_W-1:0];
    for (int i = 0; i < N_SONGS; i++) begin
      if (idx == SONG_W'(i)) b = SONG_BASE[i*ADDR_W +: ADDR_W];
    end
    return b;
  endfunction

  always_comb begin
    state_d    = state_q;
    song_idx_d = song_idx_q;
    mem_addr_d = mem_addr_q;
    freq_d     = freq_q;
    dur_cnt_d  = dur_cnt_q;
    pend_d     = pend_q;
    if (ena) begin
      if (key_menu) begin
        state_d = S_MENU;
        freq_d  = '0;
        pend_d  = 1'b0;
      end else if (key_next) begin
        song_idx_d = song_nxt;
        // In the menu key_next only browses; elsewhere it restarts on the new song.
        if (state_q != S_MENU) begin
          mem_addr_d = base_of(song_nxt);
          state_d    = S_FETCH;
          pend_d     = 1'b0;
        end
      end else begin
        case (state_q)
          S_MENU: begin
            if (key_play) begin
              mem_addr_d = base_of(song_idx_q);
              state_d    = S_FETCH;
            end
          end
          S_FETCH: begin
            state_d = S_WAIT;
            if (key_play) pend_d = 1'b1;
          end
          S_WAIT: begin
            if (ent_dur == '0) begin
              // End marker: loop the song; any pending pause carries over.
              mem_addr_d = base_of(song_idx_q);
              state_d    = S_FETCH;
              pend_d     = pend_q | key_play;
            end else begin
              freq_d    = ent_freq;
              dur_cnt_d = ent_dur - DUR_W'(1);
              state_d   = (pend_q | key_play) ? S_PAUSE : S_PLAY;
              pend_d    = 1'b0;
            end
          end
          S_PLAY: begin
            // The key_play cycle still counts as a played cycle.
            if (dur_cnt_q == '0) begin
              mem_addr_d = mem_addr_q + ADDR_W'(1);
              state_d    = S_FETCH;
              if (key_play) pend_d = 1'b1;
            end else begin
              dur_cnt_d = dur_cnt_q - DUR_W'(1);
              if (key_play) state_d = S_PAUSE;
            end
          end
          S_PAUSE: begin
            if (key_play) state_d = S_PLAY;
          end
          default: state_d = S_MENU;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_MENU;
      song_idx_q <= '0;
      mem_addr_q <= base_of('0);
      freq_q     <= '0;
      dur_cnt_q  <= '0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      song_idx_q <= song_idx_d;
      mem_addr_q <= mem_addr_d;
      freq_q     <= freq_d;
      dur_cnt_q  <= dur_cnt_d;
      pend_q     <= pend_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_rd   = ena && (state_q == S_FETCH);
  assign freq_out = freq_q;
  assign playing  = (state_q == S_PLAY);
  assign menu     = (state_q == S_MENU);
  assign song_idx = song_idx_q;

`ifdef NOTE_SEQ_TONE_EN
  logic [FREQ_W-1:0] hp_cnt_q, hp_cnt_d;
  logic              tone_q, tone_d;
  logic              tone_run, tone_restart;

  always_comb begin
    // Runs only on cycles where the FSM is actually playing (not overridden by a key).
    tone_run     = ena && (state_q == S_PLAY) && !key_menu && !key_next;
    // New note load or menu: start from a low phase with an empty counter.
    tone_restart = ena && (key_menu || (state_q == S_WAIT && !key_next && ent_dur != '0));
    hp_cnt_d     = hp_cnt_q;
    tone_d       = tone_q;
    if (tone_restart) begin
      hp_cnt_d = '0;
      tone_d   = 1'b0;
    end else if (tone_run && freq_q != '0) begin
      if (hp_cnt_q == freq_q - FREQ_W'(1)) begin
        hp_cnt_d = '0;
        tone_d   = ~tone_q;
      end else begin
        hp_cnt_d = hp_cnt_q + FREQ_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hp_cnt_q <= '0;
      tone_q   <= 1'b0;
    end else begin
      hp_cnt_q <= hp_cnt_d;
      tone_q   <= tone_d;
    end
  end

  assign tone = tone_q;
`else
  assign tone = 1'b0;
`endif

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;
  localparam int FW = 28;
  localparam int DW = 28;
  localparam int AW = 7;
  localparam int NS = 3;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst_n, ena, key_play, key_next, key_menu;
  logic [AW-1:0]    mem_addr;
  logic             mem_rd;
  logic [FW+DW-1:0] mem_data = '0;
  logic [FW-1:0]    freq_out;
  logic             tone, playing, menu;
  logic [SW-1:0]    song_idx;

  int checks = 0;
  int errors = 0;

  note_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .key_play(key_play), .key_next(key_next),
    .key_menu(key_menu), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .freq_out(freq_out), .tone(tone), .playing(playing), .menu(menu), .song_idx(song_idx)
  );

  always #5 clk = ~clk;

  // Note memory: registered read, data appears the cycle after mem_rd.
  logic [FW+DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  int base [NS] = '{1, 34, 58};

  // Reference model: where we are in a song, how many play cycles remain,
  // and how many play cycles have elapsed since the note started.
  bit m_menu, m_paused, m_pend;
  int m_ph;      // 0 = note active or menu, 1 = read issued next, 2 = data arriving
  int m_song, m_addr, m_freq, m_remain, m_k;

  task automatic model_reset();
    m_menu = 1; m_paused = 0; m_pend = 0; m_ph = 0;
    m_song = 0; m_addr = base[0]; m_freq = 0; m_remain = 0; m_k = 0;
  endtask

  task automatic model_step(input bit e, input bit km, input bit kn, input bit kp);
    logic [FW+DW-1:0] ent;
    int f, d;
    if (e) begin
      if (km) begin
        m_menu = 1; m_ph = 0; m_paused = 0; m_pend = 0; m_freq = 0; m_k = 0;
      end else if (kn) begin
        m_song = (m_song + 1) % NS;
        if (!m_menu) begin
          m_addr = base[m_song]; m_ph = 1; m_paused = 0; m_pend = 0;
        end
      end else if (m_menu) begin
        if (kp) begin m_menu = 0; m_addr = base[m_song]; m_ph = 1; end
      end else if (m_ph == 1) begin
        m_ph = 2;
        if (kp) m_pend = 1;
      end else if (m_ph == 2) begin
        ent = mem[m_addr];
        f = int'(ent[FW+DW-1:DW]);
        d = int'(ent[DW-1:0]);
        if (d == 0) begin
          m_addr = base[m_song]; m_ph = 1; m_pend = m_pend | kp;
        end else begin
          m_freq = f; m_remain = d; m_k = 0; m_ph = 0; m_paused = m_pend | kp; m_pend = 0;
        end
      end else if (m_paused) begin
        if (kp) m_paused = 0;
      end else begin
        m_k++;
        m_remain--;
        if (m_remain == 0) begin
          m_addr = (m_addr + 1) % (1 << AW); m_ph = 1; m_pend = m_pend | kp;
        end else if (kp) begin
          m_paused = 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input bit e);
    bit exp_tone;
`ifdef NOTE_SEQ_TONE_EN
    exp_tone = (m_freq != 0) && (((m_k / (m_freq == 0 ? 1 : m_freq)) % 2) == 1);
`else
    exp_tone = 1'b0;
`endif
    chk("menu", 64'(menu), 64'(m_menu));
    chk("playing", 64'(playing), 64'(!m_menu && m_ph == 0 && !m_paused));
    chk("song_idx", 64'(song_idx), 64'(m_song));
    chk("mem_addr", 64'(mem_addr), 64'(m_addr));
    chk("freq_out", 64'(freq_out), 64'(m_freq));
    chk("mem_rd", 64'(mem_rd), 64'(e && !m_menu && m_ph == 1));
    chk("tone", 64'(tone), 64'(exp_tone));
  endtask

  task automatic tick(input bit r, input bit e, input bit km, input bit kn, input bit kp);
    rst_n = !r; ena = e; key_menu = km; key_next = kn; key_play = kp;
    @(posedge clk);
    if (r) model_reset();
    else model_step(e, km, kn, kp);
    #1;
    check_all(e);
  endtask

  task automatic wait_playing(input string tag);
    int n = 0;
    while (playing !== 1'b1 && n < 300) begin
      tick(0, 1, 0, 0, 0);
      n++;
    end
    chk(tag, 64'(playing), 64'd1);
  endtask

  function automatic logic [FW+DW-1:0] ent(input int f, input int d);
    return {FW'(f), DW'(d)};
  endfunction

  initial begin
    int n;
    rst_n = 0; ena = 0; key_play = 0; key_next = 0; key_menu = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = ent($urandom_range(0, 9), $urandom_range(0, 6));
    // Song 0: one note then end marker.
    mem[1] = ent(5, 4);
    mem[2] = ent(0, 0);
    // Song 1: dur=10 note, a rest, random notes, end marker.
    mem[34] = ent(5, 10);
    mem[35] = ent(0, 3);
    for (int i = 36; i < 57; i++) mem[i] = ent($urandom_range(0, 9), $urandom_range(1, 6));
    mem[57] = ent(0, 0);
    // Song 2: short notes running through the top of memory, wrapping to 0.
    for (int i = 58; i < (1 << AW); i++) mem[i] = ent($urandom_range(1, 7), $urandom_range(1, 3));
    mem[0] = ent(3, 2);
    model_reset();

    // Reset state
    tick(1, 0, 0, 0, 0);
    tick(1, 1, 1, 1, 1);
    chk("rst_menu", 64'(menu), 64'd1);
    chk("rst_addr", 64'(mem_addr), 64'd1);
    chk("rst_song", 64'(song_idx), 64'd0);
    chk("rst_freq", 64'(freq_out), 64'd0);

    // Note timing: {5,4} then end marker
    tick(0, 1, 0, 0, 1);
    chk("fetch_rd", 64'(mem_rd), 64'd1);
    tick(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, 0, 0, 0);
      chk("note_play", 64'(playing), 64'd1);
      chk("note_freq", 64'(freq_out), 64'd5);
    end
    tick(0, 1, 0, 0, 0);
    chk("note_end_play", 64'(playing), 64'd0);
    chk("note_next_addr", 64'(mem_addr), 64'd2);
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    chk("loop_addr", 64'(mem_addr), 64'd1);
    chk("loop_rd", 64'(mem_rd), 64'd1);

    // key_next while playing -> song 1, then pause at 2nd play cycle of dur=10
    wait_playing("wait_s0");
    tick(0, 1, 0, 1, 0);
    chk("next_song", 64'(song_idx), 64'd1);
    chk("next_addr", 64'(mem_addr), 64'd34);
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 1);
    chk("paused", 64'(playing), 64'd0);
    for (int i = 0; i < 20; i++) tick(0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 1);
    n = 0;
    while (playing === 1'b1 && n < 50) begin
      n++;
      tick(0, 1, 0, 0, 0);
    end
    chk("resume_len", 64'(n), 64'd8);

    // ena low mid-note with key pulses
    wait_playing("wait_s1");
    tick(0, 1, 0, 0, 0);
    for (int i = 0; i < 50; i++)
      tick(0, 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    for (int i = 0; i < 10; i++) tick(0, 1, 0, 0, 0);

    // Song 2, address wrap, song index wrap
    tick(0, 1, 0, 1, 0);
    chk("song2_idx", 64'(song_idx), 64'd2);
    chk("song2_addr", 64'(mem_addr), 64'd58);
    n = 0;
    while (mem_addr !== '0 && n < 3000) begin
      tick(0, 1, 0, 0, 0);
      n++;
    end
    chk("addr_wrap", 64'(mem_addr), 64'd0);
    wait_playing("wait_s2");
    tick(0, 1, 0, 1, 0);
    chk("wrap_song", 64'(song_idx), 64'd0);
    chk("wrap_addr", 64'(mem_addr), 64'd1);
    chk("wrap_fetch", 64'(mem_rd), 64'd1);

    // All three keys together
    wait_playing("wait_s0b");
    tick(0, 1, 1, 1, 1);
    chk("simul_menu", 64'(menu), 64'd1);
    chk("simul_song", 64'(song_idx), 64'd0);
    chk("simul_freq", 64'(freq_out), 64'd0);

    // Reset mid-note on song 1
    tick(0, 1, 0, 1, 0);
    chk("menu_browse", 64'(song_idx), 64'd1);
    tick(0, 1, 0, 0, 1);
    wait_playing("wait_s1b");
    tick(0, 1, 0, 0, 0);
    tick(1, 1, 0, 1, 1);
    chk("midrst_menu", 64'(menu), 64'd1);
    chk("midrst_freq", 64'(freq_out), 64'd0);
    chk("midrst_song", 64'(song_idx), 64'd0);
    chk("midrst_addr", 64'(mem_addr), 64'd1);

    // Random traffic
    for (int i = 0; i < 600; i++)
      tick($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
